// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: ResultSrc selects and the stage FSM states.
package riscv_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Loads and stores are the only ops that touch the data bus.
  function automatic logic is_access(input logic mem_write, input logic [1:0] result_src);
    return mem_write || (result_src == RES_MEM);
  endfunction

endpackage

// File: rtl/memory_writeback_register.sv
// MEM/WB pipeline register; a bubble loads an all-zero (no register write) entry.
module memory_writeback_register
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic        m_reg_write,
  input  logic [1:0]  m_result_src,
  input  logic [31:0] m_alu_result,
  input  logic [31:0] m_read_data,
  input  logic [31:0] m_pc_plus4,
  input  logic [4:0]  m_rd,
  output logic        w_reg_write,
  output logic [1:0]  w_result_src,
  output logic [31:0] w_alu_result,
  output logic [31:0] w_read_data,
  output logic [31:0] w_pc_plus4,
  output logic [4:0]  w_rd
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      w_reg_write  <= 1'b0;
      w_result_src <= RES_ALU;
      w_alu_result <= '0;
      w_read_data  <= '0;
      w_pc_plus4   <= '0;
      w_rd         <= '0;
    end else begin
      w_reg_write  <= m_reg_write;
      w_result_src <= m_result_src;
      w_alu_result <= m_alu_result;
      w_read_data  <= m_read_data;
      w_pc_plus4   <= m_pc_plus4;
      w_rd         <= m_rd;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: drives the data bus, stalls upstream until mem_ready.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [4:0]  RdM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        MemErrW
);

  mem_state_t  state;
  logic        access;
  logic        abort;
  logic        bubble;
  logic [31:0] read_data;

  assign access = is_access(MemWriteM, ResultSrcM);

  // Upstream holds the EX/MEM register while stalled, so the bus fields stay stable in WAIT.
  assign mem_req   = !reset && (state == WAIT || access);
  assign mem_we    = mem_req && MemWriteM;
  assign mem_addr  = ALUResultM;
  assign mem_wdata = WriteDataM;

  assign StallM    = mem_req && !mem_ready && !abort;
  assign bubble    = StallM || abort;
  assign read_data = (ResultSrcM == RES_MEM) ? mem_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (access && !mem_ready) state <= WAIT;
        WAIT:    if (mem_ready || abort) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_count;

  // A ready response in the final WAIT cycle still wins over the abort.
  assign abort = (state == WAIT) && !mem_ready && (wait_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state != WAIT || mem_ready || abort) begin
      wait_count <= '0;
    end else begin
      wait_count <= wait_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MemErrW <= 1'b0;
    end else begin
      MemErrW <= abort;
    end
  end
`else
  assign abort   = 1'b0;
  assign MemErrW = 1'b0;
`endif

  memory_writeback_register wb_reg (
    .clk          (clk),
    .reset        (reset),
    .bubble       (bubble),
    .m_reg_write  (RegWriteM),
    .m_result_src (ResultSrcM),
    .m_alu_result (ALUResultM),
    .m_read_data  (read_data),
    .m_pc_plus4   (PCPlus4M),
    .m_rd         (RdM),
    .w_reg_write  (RegWriteW),
    .w_result_src (ResultSrcW),
    .w_alu_result (ALUResultW),
    .w_read_data  (ReadDataW),
    .w_pc_plus4   (PCPlus4W),
    .w_rd         (RdW)
  );

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: a transaction-level model of each op's lifetime
// (cycles held, memory latency, optional timeout) predicts bus, stall and W-stage results.
module tb_memory_stage;
  import riscv_pkg::*;

`ifdef MEM_TIMEOUT_EN
  localparam int TIMEOUT = 4;
  localparam bit TO_EN   = 1'b1;
`else
  localparam int TIMEOUT = 16;
  localparam bit TO_EN   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, StallM;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        MemErrW;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW), .MemErrW(MemErrW)
  );

  // One pipeline op plus how the memory answers it: ready after lat held cycles,
  // and an optional reset pulse injected after resetAt held cycles.
  typedef struct {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          lat;
    int          resetAt;
  } op_t;

  op_t  opQ[$];
  op_t  cur;
  int   checks = 0;
  int   failures = 0;
  bit   holdOp = 1'b0;
  int   age = 0;

  logic        expRw;
  logic [1:0]  expRs;
  logic [31:0] expAlu, expRdata, expPc4;
  logic [4:0]  expRd;
  logic        expErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic op_t mkOp(input logic rw, input logic mw, input logic [1:0] rs,
                               input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                               input int lat, input logic [31:0] rdata, input int resetAt);
    op_t o;
    o.rw = rw; o.mw = mw; o.rs = rs; o.alu = alu; o.wd = wd; o.rd = rd;
    o.pc4 = alu + 32'h1000; o.lat = lat; o.rdata = rdata; o.resetAt = resetAt;
    return o;
  endfunction

  function automatic op_t randomOp();
    op_t o;
    int  kind = $urandom_range(0, 4);
    o = mkOp(1'($urandom), 1'b0, RES_ALU, $urandom, $urandom, 5'($urandom),
             $urandom_range(0, 3), $urandom, -1);
    o.pc4 = $urandom;
    case (kind)
      1:       o.rs = RES_MEM;
      2:       o.mw = 1'b1;
      3:       o.rs = RES_PC4;
      4:       o.rw = 1'b0;
      default: o.rs = RES_ALU;
    endcase
    if ($urandom_range(0, 7) == 0) o.lat = TIMEOUT + 2;
    return o;
  endfunction

  task automatic clearExpected();
    expRw = 1'b0; expRs = 2'b00; expAlu = '0; expRdata = '0; expPc4 = '0; expRd = '0;
  endtask

  // One clock: check last cycle's W prediction, present the current op, check the bus.
  task automatic applyStimulus();
    bit          acc, rst, ready, abort, stall;
    logic [31:0] rdata;
    @(posedge clk);
    #1;
    checkOutput("RegWriteW",  32'(RegWriteW),  32'(expRw));
    checkOutput("ResultSrcW", 32'(ResultSrcW), 32'(expRs));
    checkOutput("ALUResultW", ALUResultW,      expAlu);
    checkOutput("ReadDataW",  ReadDataW,       expRdata);
    checkOutput("PCPlus4W",   PCPlus4W,        expPc4);
    checkOutput("RdW",        32'(RdW),        32'(expRd));
    checkOutput("MemErrW",    32'(MemErrW),    32'(expErr));

    if (!holdOp) begin
      cur = (opQ.size() > 0) ? opQ.pop_front() : randomOp();
      age = 0;
    end
    acc   = cur.mw || (cur.rs == RES_MEM);
    rst   = acc && (age == cur.resetAt);
    ready = acc && !rst && (age == cur.lat);
    rdata = ready ? cur.rdata : $urandom;

    reset      = rst;
    RegWriteM  = cur.rw;
    MemWriteM  = cur.mw;
    ResultSrcM = cur.rs;
    ALUResultM = cur.alu;
    WriteDataM = cur.wd;
    PCPlus4M   = cur.pc4;
    RdM        = cur.rd;
    mem_ready  = acc ? ready : 1'($urandom);
    mem_rdata  = rdata;
    #2;

    if (rst) begin
      checkOutput("mem_req_in_reset", 32'(mem_req), 32'd0);
      checkOutput("StallM_in_reset",  32'(StallM),  32'd0);
      clearExpected();
      expErr      = 1'b0;
      cur.resetAt = -1;
      age         = 0;
      holdOp      = acc;
    end else begin
      abort = TO_EN && acc && !ready && (age == TIMEOUT);
      stall = acc && !ready && !abort;
      checkOutput("mem_req", 32'(mem_req), 32'(acc));
      checkOutput("StallM",  32'(StallM),  32'(stall));
      if (acc) begin
        checkOutput("mem_we",    32'(mem_we), 32'(cur.mw));
        checkOutput("mem_addr",  mem_addr,    cur.alu);
        checkOutput("mem_wdata", mem_wdata,   cur.wd);
      end
      if (stall || abort) begin
        clearExpected();
      end else begin
        expRw    = cur.rw;
        expRs    = cur.rs;
        expAlu   = cur.alu;
        expRdata = (cur.rs == RES_MEM) ? rdata : 32'd0;
        expPc4   = cur.pc4;
        expRd    = cur.rd;
      end
      expErr = abort;
      holdOp = stall;
      if (stall) age++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    RegWriteM  = 1'b1;
    MemWriteM  = 1'b0;
    ResultSrcM = RES_MEM;
    ALUResultM = 32'h40;
    WriteDataM = '0;
    PCPlus4M   = '0;
    RdM        = 5'd1;
    mem_ready  = 1'b1;
    mem_rdata  = 32'h12345678;
    clearExpected();
    expErr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_mem_req",   32'(mem_req),   32'd0);
    checkOutput("reset_StallM",    32'(StallM),    32'd0);
    checkOutput("reset_RegWriteW", 32'(RegWriteW), 32'd0);
    checkOutput("reset_MemErrW",   32'(MemErrW),   32'd0);

    opQ.push_back(mkOp(1'b1, 1'b0, RES_ALU, 32'h1234, 32'h0, 5'd5, 0, 32'h0, -1));
    opQ.push_back(mkOp(1'b0, 1'b0, RES_ALU, 32'h55, 32'h0, 5'd0, 0, 32'h0, -1));
    opQ.push_back(mkOp(1'b1, 1'b0, RES_MEM, 32'h100, 32'h0, 5'd7, 0, 32'hDEADBEEF, -1));
    opQ.push_back(mkOp(1'b0, 1'b1, RES_ALU, 32'h200, 32'hA5A5A5A5, 5'd0, 3, 32'h0, -1));
    opQ.push_back(mkOp(1'b1, 1'b0, RES_MEM, 32'h300, 32'h0, 5'd9, 3, 32'hCAFEF00D, 2));
    opQ.push_back(mkOp(1'b1, 1'b0, RES_MEM, 32'h400, 32'h0, 5'd10, TIMEOUT + 2, 32'hBAD0BAD0, -1));
    opQ.push_back(mkOp(1'b0, 1'b0, RES_ALU, 32'h66, 32'h0, 5'd0, 0, 32'h0, -1));
    opQ.push_back(mkOp(1'b1, 1'b0, RES_MEM, 32'h500, 32'h0, 5'd11, TIMEOUT, 32'h600DF00D, -1));
    opQ.push_back(mkOp(1'b1, 1'b1, RES_ALU, 32'h504, 32'h13579BDF, 5'd12, 0, 32'hFFFFFFFF, -1));

    for (int i = 0; i < 400; i++) begin
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
